// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, presents the current instruction
// with a valid qualifier, follows branch decisions from the control unit,
// and runs the start/halt/done handshake with a retired-instruction count.
module fetch_unit #(
   parameter int PC_W  = 10,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PC_W-1:0]  start_addr,
   input  logic             halt,
   input  logic             ctrl_branch,
   input  logic             take_branch,
   input  logic [PC_W-1:0]  branch_target,
   output logic [PC_W-1:0]  imem_addr,
   input  logic [8:0]       imem_data,
   output logic [8:0]       instruction,
   output logic             instr_valid,
   output logic [PC_W-1:0]  pc,
   output logic             done,
   output logic [CNT_W-1:0] instr_count,
   output logic             pc_wrapped
);

   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

   localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state, w_state_nxt;
   logic [PC_W-1:0]  r_pc, w_pc_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_done, w_done_nxt;
   logic             r_wrap, w_wrap_nxt;
   logic             w_run;

   // Valid and instruction are decoded from state so reset kills them at once.
   assign w_run       = (r_state == RUN);
   assign instr_valid = w_run;
   assign instruction = w_run ? imem_data : 9'b0;
   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign done        = r_done;
   assign instr_count = r_cnt;
   assign pc_wrapped  = r_wrap;

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_pc    <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
         r_wrap  <= w_wrap_nxt;
      end
   end

   // Next state and next PC; halt outranks branch, start only leaves IDLE/HALTED.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = r_done;
      w_wrap_nxt  = r_wrap;
      case (r_state)
         IDLE, HALTED: begin
            if (start) begin
               w_state_nxt = RUN;
               w_pc_nxt    = start_addr;
               w_cnt_nxt   = '0;
               w_done_nxt  = 1'b0;
               w_wrap_nxt  = 1'b0;
            end
         end
         RUN: begin
            // Every RUN cycle retires one instruction, halt included.
            if (!(&r_cnt)) w_cnt_nxt = r_cnt + CNT_ONE;
            if (halt) begin
               w_state_nxt = HALTED;
               w_done_nxt  = 1'b1;
            end else if (ctrl_branch && take_branch) begin
               w_pc_nxt = branch_target;
            end else begin
               w_pc_nxt = r_pc + PC_ONE;
               if (&r_pc) w_wrap_nxt = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the control unit.
- Owns the program counter and presents the current 9-bit instruction from instruction memory, with a valid qualifier.
- Consumes the control unit's branch decision (ctrl_branch, take_branch) and the LUT-resolved branch target.
- Runs a start/halt/done program-execution handshake with the test harness and counts retired instructions.

Parameters:
- PC_W, 10, program counter and instruction-memory address width.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution at start_addr.
- start_addr  in  PC_W  program entry address, sampled on start.
- halt  in  1  from control unit: current instruction is HALT.
- ctrl_branch  in  1  from control unit: current instruction is a branch.
- take_branch  in  1  from control unit: branch condition true.
- branch_target  in  PC_W  absolute target from branch LUT.
- imem_addr  out  PC_W  instruction memory address; always equals pc.
- imem_data  in  9  instruction memory data; combinational read of imem_addr.
- instruction  out  9  instruction to control unit.
- instr_valid  out  1  instruction is live; datapath gates reg/mem writes with it.
- pc  out  PC_W  current program counter.
- done  out  1  program has halted.
- instr_count  out  CNT_W  retired instructions since last start.
- pc_wrapped  out  1  sticky: PC incremented past all-ones.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, pc=0, done=0, instr_count=0, pc_wrapped=0. instr_valid=0 while reset is held.
- States are IDLE, RUN and HALTED. Outputs are registered except instr_valid, instruction and imem_addr.
- instruction = imem_data in RUN, 9'b0 otherwise.
- instr_valid = 1 only in RUN.
- IDLE:
  - pc holds.
  - On start: pc<=start_addr, instr_count<=0, pc_wrapped<=0, done<=0, go to RUN.
- RUN: each cycle retires exactly one instruction (instr_count+1, saturating at all-ones). Next pc priority:
  - 1. halt=1: pc holds, done<=1, go to HALTED. The halt instruction is counted. Branch inputs are ignored.
  - 2. ctrl_branch=1 and take_branch=1: pc<=branch_target.
  - 3. Otherwise: pc<=pc+1, modulo 2^PC_W. On the all-ones to 0 transition, pc_wrapped<=1.
  - take_branch with ctrl_branch=0 is ignored.
  - start in RUN is ignored; no restart mid-program.
- HALTED:
  - pc, instr_count and done hold.
  - On start: same action as start in IDLE (done clears on the same edge), go to RUN.
- Latency:
  - The first instruction is valid in the cycle after the start edge.
  - A taken branch presents the target instruction in the next cycle; there are no delay slots and no bubbles.
  - done rises on the clock edge that retires halt.
- Reset asserted mid-RUN: immediate return to IDLE with reset values; no instruction retires in that cycle.
- branch_target==pc while taken: pc holds (tight loop), and instr_count still increments each cycle.
- halt and start in the same RUN cycle: halt wins, and start is dropped.

Test Plan:
- Reset, then start with start_addr=0x010 and no branch/halt for 4 cycles -> pc sequence 0x010,0x011,0x012,0x013, instr_valid=1, instr_count=4.
- In RUN at pc=0x020, ctrl_branch=1, take_branch=1, branch_target=0x100 -> next pc=0x100. Same with take_branch=0 -> next pc=0x021. take_branch=1 with ctrl_branch=0 -> 0x021.
- Run from 0x005, assert halt at pc=0x007 -> done=1 after that edge, pc stays 0x007, instr_count=3, instruction=0, instr_valid=0. Pulse start with start_addr=0x000 -> done=0, pc=0x000, instr_count=0.
- start_addr=0x3FF with PC_W=10, no branch -> pc goes to 0x000 and pc_wrapped=1. The flag persists until the next start.
- Assert reset asynchronously mid-cycle in RUN at pc=0x055 -> pc=0, state IDLE, instr_valid=0 immediately, without waiting for a clock edge. A subsequent start works normally.
- halt=1, start=1 and a taken branch to 0x200 in the same RUN cycle -> HALTED, pc unchanged, done=1, no restart.
